signed_sub_with_overflow_serial: RTL and testbench

//   Multi-cycle signed two's-complement subtractor, diff = a - b, with signed overflow detection.
//   It is the counterpart of the combinational signed adder: it computes a + ~b + 1 one CHUNK

---
 rtl/sub_serial_pkg.sv | 29 ++
 rtl/signed_sub_with_overflow_serial_sub_chunk.sv | 29 ++
 rtl/signed_sub_with_overflow_serial.sv | 154 +++++++++++++++
 tb/tb_signed_sub_with_overflow_serial.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sub_serial_pkg
//  Purpose  : Shared types and helpers for the serial signed subtractor.
//             Provides the FSM state type, the chunk-count helper and the
//             index-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Number of CHUNK-wide slices processed per operation.
    function automatic int calc_num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the slice index. It is never narrower than one bit, so a
    // single-slice configuration still has a legal counter.
    function automatic int calc_idx_width(input int num_chunks);
        return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
    endfunction

endpackage
`default_nettype wire

// File: rtl/signed_sub_with_overflow_serial_sub_chunk.sv
`default_nettype none
// ============================================================================
//  Module   : sub_chunk
//  Purpose  : One CHUNK-wide slice of a ripple subtractor.
//             The slice computes {cout, s} = x + ~y + cin.
//  Ports    : x    in   CHUNK  minuend slice
//             y    in   CHUNK  subtrahend slice (inverted internally)
//             cin  in   1      carry in (1 on the first slice supplies the +1)
//             s    out  CHUNK  difference slice
//             cout out  1      carry out to the next slice
//  Revision : 1.0  initial release
// ============================================================================
module sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] w_sum;

    assign w_sum       = {1'b0, x} + {1'b0, ~y} + {{CHUNK{1'b0}}, cin};
    assign {cout, s}   = w_sum;

endmodule
`default_nettype wire

// File: rtl/signed_sub_with_overflow_serial.sv
`default_nettype none
// ============================================================================
//  Module   : signed_sub_with_overflow_serial
//  Purpose  : Multi-cycle signed subtractor, diff = a - b, with signed overflow.
//             One CHUNK slice of a + ~b + 1 is computed per cycle, and the
//             carry ripples through a register.
//  Ports    : clk         in   1      clock, rising edge
//             rst         in   1      asynchronous active-high reset
//             up_valid    in   1      operands valid
//             up_ready    out  1      ready to accept operands (IDLE only)
//             a           in   WIDTH  minuend, signed
//             b           in   WIDTH  subtrahend, signed
//             down_valid  out  1      result valid (DONE only)
//             down_ready  in   1      consumer accepts result
//             diff        out  WIDTH  a - b modulo 2^WIDTH
//             overflow    out  1      signed overflow of a - b
//  Revision : 1.0  initial release
// ============================================================================
module signed_sub_with_overflow_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] diff,
    output logic             overflow
);
    import sub_serial_pkg::*;

    localparam int                 c_N        = calc_num_chunks(WIDTH, CHUNK);
    localparam int                 c_IDX_W    = calc_idx_width(c_N);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);

    sub_state_t         r_state;
    sub_state_t         w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_carry;
    logic               r_overflow;
    logic [c_IDX_W-1:0] r_idx;

    logic [CHUNK-1:0]   w_a_slice;
    logic [CHUNK-1:0]   w_b_slice;
    logic [CHUNK-1:0]   w_s;
    logic               w_cout;
    logic               w_last;

    assign w_a_slice = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_slice = r_b[r_idx*CHUNK +: CHUNK];
    assign w_last    = (r_idx == c_LAST_IDX);

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .x    (w_a_slice),
        .y    (w_b_slice),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        up_ready     = 1'b0;
        down_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                up_ready = 1'b1;
                if (up_valid) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                down_valid = 1'b1;
                if (down_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, slice ripple, result and overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_diff     <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (up_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_carry    <= 1'b1;     // the +1 of the two's complement of b
                        r_idx      <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                BUSY: begin
                    r_diff[r_idx*CHUNK +: CHUNK] <= w_s;
                    r_carry                      <= w_cout;
                    r_idx                        <= w_last ? '0 : r_idx + 1'b1;
                    // The top slice carries the result sign bit, so overflow
                    // is resolved in the same cycle that slice is written.
                    if (w_last) begin
                        r_overflow <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                      (w_s[CHUNK-1] != r_a[WIDTH-1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff     = r_diff;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_signed_sub_with_overflow_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_signed_sub_with_overflow_serial
//  Purpose  : Self-checking bench for the serial signed subtractor, covering
//             the 16/4 configuration (vector table, back-pressure, reset abort)
//             and the 4/4 single-slice configuration (named and exhaustive).
//  Revision : 1.0  initial release
// ============================================================================
module tb_signed_sub_with_overflow_serial;

    logic        clk = 1'b0;
    logic        rst;

    logic        up_valid, up_ready, down_valid, down_ready, overflow;
    logic [15:0] a, b, diff;

    logic        up_valid_4, up_ready_4, down_valid_4, down_ready_4, overflow_4;
    logic [3:0]  a_4, b_4, diff_4;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] d; logic o; } vec16_t;
    typedef struct { logic [15:0] d; logic o; } exp16_t;
    typedef struct { logic [3:0] d;  logic o; } exp4_t;

    exp16_t sb16[$];
    exp4_t  sb4[$];
    vec16_t vecs[10];

    always #5 clk = ~clk;

    signed_sub_with_overflow_serial #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .a          (a),
        .b          (b),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .diff       (diff),
        .overflow   (overflow)
    );

    signed_sub_with_overflow_serial #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid_4),
        .up_ready   (up_ready_4),
        .a          (a_4),
        .b          (b_4),
        .down_valid (down_valid_4),
        .down_ready (down_ready_4),
        .diff       (diff_4),
        .overflow   (overflow_4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 16-bit operation; stall = cycles of down_ready=0 once DONE is reached.
    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [15:0] ed, input logic eo,
                        input int stall, input string nm);
        int     n;
        logic   got;
        logic   busy_ready_seen;
        exp16_t e;
        n = 0;
        while (!up_ready && n < 20) begin tick(); n++; end
        chk({nm, "_up_ready"}, up_ready, 1);
        a          = ta;
        b          = tb_v;
        up_valid   = 1'b1;
        down_ready = (stall == 0);
        sb16.push_back('{ed, eo});
        tick();                                  // accept edge
        up_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        n = 0; got = 1'b0; busy_ready_seen = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            got = down_valid;
            if (up_ready) busy_ready_seen = 1'b1;
        end
        chk({nm, "_latency"}, n, 4);
        chk({nm, "_busy_up_ready"}, busy_ready_seen, 0);
        for (int i = 0; i < stall; i++) begin
            chk({nm, "_hold_valid"}, down_valid, 1);
            chk({nm, "_hold_up_ready"}, up_ready, 0);
            chk({nm, "_hold_diff"}, diff, ed);
            chk({nm, "_hold_ovf"}, overflow, eo);
            up_valid = 1'b1;                     // must be ignored in DONE
            a        = 16'h0001;
            b        = 16'h0001;
            tick();
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        chk({nm, "_valid"}, down_valid, 1);
        if (sb16.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
        end else begin
            e = sb16.pop_front();
            chk({nm, "_diff"}, diff, e.d);
            chk({nm, "_ovf"}, overflow, e.o);
        end
        tick();
        chk({nm, "_after_valid"}, down_valid, 0);
        chk({nm, "_after_ready"}, up_ready, 1);
    endtask

    // One single-slice operation on the 4-bit instance.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v,
                       input logic [3:0] ed, input logic eo, input string nm);
        int    n;
        logic  got;
        exp4_t e;
        n = 0;
        while (!up_ready_4 && n < 20) begin tick(); n++; end
        chk({nm, "_up_ready"}, up_ready_4, 1);
        a_4        = ta;
        b_4        = tb_v;
        up_valid_4 = 1'b1;
        sb4.push_back('{ed, eo});
        tick();
        up_valid_4 = 1'b0;
        a_4        = 4'($urandom);
        b_4        = 4'($urandom);
        n = 0; got = 1'b0;
        while (!got && n < 10) begin
            tick();
            n++;
            got = down_valid_4;
        end
        chk({nm, "_latency"}, n, 1);
        if (sb4.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
        end else begin
            e = sb4.pop_front();
            chk({nm, "_diff"}, diff_4, e.d);
            chk({nm, "_ovf"}, overflow_4, e.o);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   sa, sb_i, tr;
        logic dv_seen;

        vecs[0] = '{16'd5,    16'd3,    16'h0002, 1'b0};
        vecs[1] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b1};
        vecs[2] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0};
        vecs[4] = '{16'h0000, 16'h8000, 16'h8000, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 16'h0000, 1'b0};
        vecs[6] = '{16'h1234, 16'h0234, 16'h1000, 1'b0};
        vecs[7] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b0};
        vecs[8] = '{16'h7FFF, 16'h8000, 16'hFFFF, 1'b1};
        vecs[9] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b1};

        rst          = 1'b1;
        up_valid     = 1'b0;
        down_ready   = 1'b1;
        a            = '0;
        b            = '0;
        up_valid_4   = 1'b0;
        down_ready_4 = 1'b1;
        a_4          = '0;
        b_4          = '0;
        repeat (2) tick();
        chk("reset_up_ready", up_ready, 1);
        chk("reset_down_valid", down_valid, 0);
        chk("reset_diff", diff, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset4_up_ready", up_ready_4, 1);
        chk("reset4_down_valid", down_valid_4, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            op16(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].o, 0, $sformatf("vec%0d", i));
        end

        // Back-pressure: 100 - 200 held for three cycles in DONE.
        op16(16'd100, 16'd200, 16'hFF9C, 1'b0, 3, "bp_100_200");

        // Reset during the second BUSY cycle aborts the operation.
        a        = 16'd5;
        b        = 16'd3;
        up_valid = 1'b1;
        tick();                                  // accept edge
        up_valid = 1'b0;
        tick();                                  // first BUSY edge done
        #2;
        rst = 1'b1;
        #1;
        chk("abort_up_ready", up_ready, 1);
        chk("abort_down_valid", down_valid, 0);
        chk("abort_diff", diff, 0);
        chk("abort_ovf", overflow, 0);
        tick();
        rst = 1'b0;
        dv_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (down_valid) dv_seen = 1'b1;
        end
        chk("abort_no_valid", dv_seen, 0);
        op16(16'd7, 16'd9, 16'hFFFE, 1'b0, 0, "post_abort_7_9");

        // Single-slice configuration.
        op4(4'hC, 4'h5, 4'h7, 1'b1, "w4_neg4_minus5");
        op4(4'h3, 4'h5, 4'hE, 1'b0, "w4_3_minus5");
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                sa   = (ia >= 8) ? ia - 16 : ia;
                sb_i = (ib >= 8) ? ib - 16 : ib;
                tr   = sa - sb_i;
                op4(4'(ia), 4'(ib), 4'(tr), (tr > 7) || (tr < -8),
                    $sformatf("ex4_%0d_%0d", ia, ib));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
